// File: rtl/priority_scan_encoder.sv
// Priority scan encoder: captures a request vector, then emits the index of
// every set bit one beat at a time, in priority order, over valid/ready.
// Successor to the 4-to-2 priority encoder; an all-zero vector yields a single
// beat with index 0, which matches the old encoder's default output.
module priority_scan_encoder #(
  parameter int WIDTH      = 8,
  parameter int IDXW       = $clog2(WIDTH),
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDXW-1:0]  out_idx,
  output logic             out_last,
  output logic             out_zero,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    OUT  = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pending_q;
  logic [WIDTH-1:0] pending_d;
  logic             zero_q;
  logic [IDXW-1:0]  selIdx;
  logic             oneLeft;

  // Pick the winning index out of the captured vector; later loop iterations
  // override earlier ones, so the iteration order sets the priority.
  always_comb begin
    selIdx = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pending_q[i]) selIdx = IDXW'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pending_q[i]) selIdx = IDXW'(i);
      end
    end
  end

  // Exactly one bit left means the current beat is the final one; pending_d
  // is the vector after the selected bit has been serviced.
  always_comb begin
    oneLeft   = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);
    pending_d = pending_q & ~(WIDTH'(1) << selIdx);
  end

  // The handshake outputs come straight from the state register, so the
  // async reset clears them immediately; in_ready is also forced low in reset.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == OUT);
  assign busy      = (state_q == OUT);
  assign out_idx   = selIdx;
  assign out_last  = (state_q == OUT) && (oneLeft || zero_q);
  assign out_zero  = zero_q;

  // Capture in IDLE, then retire one index per accepted beat until the last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            pending_q <= in_vec;
            zero_q    <= (in_vec == '0);
            state_q   <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            pending_q <= pending_d;
            if (out_last) begin
              zero_q  <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Bench for priority_scan_encoder: three instances (8-bit high-first,
// 8-bit low-first, 4-bit high-first) share the clock and reset; one is
// selected at a time and its beats are checked against a scoreboard queue.
module tb_priority_scan_encoder;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
    logic       zero;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inValid = 1'b0;
  logic [7:0] inVec = '0;
  logic       outReady = 1'b0;
  int         sel = 0;

  logic       rdyA, valA, lastA, zeroA, busyA;
  logic [2:0] idxA;
  logic       rdyB, valB, lastB, zeroB, busyB;
  logic [2:0] idxB;
  logic       rdyC, valC, lastC, zeroC, busyC;
  logic [1:0] idxC;

  logic       obsReady, obsValid, obsLast, obsZero, obsBusy;
  logic [2:0] obsIdx;

  beat_t      expQ[$];
  int         testCount = 0;
  int         failCount = 0;

  always #5 clk = ~clk;

  priority_scan_encoder #(.WIDTH(8), .HIGH_FIRST(1'b1)) dutHigh (
    .clk(clk), .rst(rst),
    .in_valid(inValid && sel == 0), .in_ready(rdyA), .in_vec(inVec),
    .out_valid(valA), .out_ready(outReady && sel == 0),
    .out_idx(idxA), .out_last(lastA), .out_zero(zeroA), .busy(busyA)
  );

  priority_scan_encoder #(.WIDTH(8), .HIGH_FIRST(1'b0)) dutLow (
    .clk(clk), .rst(rst),
    .in_valid(inValid && sel == 1), .in_ready(rdyB), .in_vec(inVec),
    .out_valid(valB), .out_ready(outReady && sel == 1),
    .out_idx(idxB), .out_last(lastB), .out_zero(zeroB), .busy(busyB)
  );

  priority_scan_encoder #(.WIDTH(4), .HIGH_FIRST(1'b1)) dutNarrow (
    .clk(clk), .rst(rst),
    .in_valid(inValid && sel == 2), .in_ready(rdyC), .in_vec(inVec[3:0]),
    .out_valid(valC), .out_ready(outReady && sel == 2),
    .out_idx(idxC), .out_last(lastC), .out_zero(zeroC), .busy(busyC)
  );

  // Route the selected instance's outputs onto one set of observation wires.
  always_comb begin
    obsReady = rdyA; obsValid = valA; obsLast = lastA;
    obsZero  = zeroA; obsBusy = busyA; obsIdx = idxA;
    if (sel == 1) begin
      obsReady = rdyB; obsValid = valB; obsLast = lastB;
      obsZero  = zeroB; obsBusy = busyB; obsIdx = idxB;
    end else if (sel == 2) begin
      obsReady = rdyC; obsValid = valC; obsLast = lastC;
      obsZero  = zeroC; obsBusy = busyC; obsIdx = {1'b0, idxC};
    end
  end

  // One comparison: counts it, and reports and counts a failure.
  task automatic checkOutput(input string name, input logic [31:0] obs, input logic [31:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", name, obs, exp);
    end
  endtask

  // The 4-to-2 encoder this block replaces: highest set bit, 0 when empty.
  function automatic int legacyEncode(input logic [3:0] v);
    legacyEncode = 0;
    for (int i = 0; i < 4; i++) if (v[i]) legacyEncode = i;
  endfunction

  // Reference model: list the set bits in scan order and queue one beat each.
  task automatic pushExpected(input logic [7:0] vec, input int w, input bit hf);
    int    order[8];
    int    n = 0;
    beat_t b;
    for (int k = 0; k < w; k++) begin
      int pos = hf ? (w - 1 - k) : k;
      if (vec[pos]) begin
        order[n] = pos;
        n++;
      end
    end
    if (n == 0) begin
      b.idx = 3'd0; b.last = 1'b1; b.zero = 1'b1;
      expQ.push_back(b);
    end else begin
      for (int k = 0; k < n; k++) begin
        b.idx = 3'(order[k]); b.last = (k == n - 1); b.zero = 1'b0;
        expQ.push_back(b);
      end
    end
  endtask

  // Offer one vector to instance s, hold off the consumer for `stall` cycles,
  // then drain every beat at full rate and confirm the return to IDLE.
  task automatic applyStimulus(input int s, input logic [7:0] vec, input int stall,
                               output int firstIdx);
    beat_t e;
    bit    first = 1'b1;
    firstIdx = -1;
    sel = s;
    @(negedge clk);
    checkOutput("ready_before_accept", obsReady, 1);
    inVec = vec; inValid = 1'b1; outReady = 1'b0;
    pushExpected(vec, (s == 2) ? 4 : 8, s != 1);
    @(negedge clk);
    inValid = 1'b0;
    inVec = 8'hA5;
    for (int k = 0; k < stall; k++) begin
      checkOutput("stall_valid", obsValid, 1);
      checkOutput("stall_idx", obsIdx, expQ[0].idx);
      checkOutput("stall_ready_low", obsReady, 0);
      @(negedge clk);
    end
    outReady = 1'b1;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      if (first) firstIdx = int'(obsIdx);
      first = 1'b0;
      checkOutput("beat_valid", obsValid, 1);
      checkOutput("beat_idx", obsIdx, e.idx);
      checkOutput("beat_last", obsLast, e.last);
      checkOutput("beat_zero", obsZero, e.zero);
      checkOutput("beat_busy", obsBusy, 1);
      @(negedge clk);
    end
    outReady = 1'b0;
    checkOutput("idle_ready", obsReady, 1);
    checkOutput("idle_valid", obsValid, 0);
    checkOutput("idle_busy", obsBusy, 0);
  endtask

  initial begin
    int firstIdx;

    // Reset behaviour and release with no request pending.
    repeat (2) @(negedge clk);
    checkOutput("reset_ready", obsReady, 0);
    checkOutput("reset_valid", obsValid, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("release_ready", obsReady, 1);
    checkOutput("release_valid", obsValid, 0);
    checkOutput("release_busy", obsBusy, 0);
    checkOutput("release_idx", obsIdx, 0);

    // Multi-bit vector at full rate: 7, 5, 2, 1.
    applyStimulus(0, 8'b1010_0110, 0, firstIdx);
    // All-zero vector: single flagged beat.
    applyStimulus(0, 8'h00, 0, firstIdx);
    // Backpressure for three cycles: 5 held, then 5, 4.
    applyStimulus(0, 8'b0011_0000, 3, firstIdx);
    // Top bit alone: single beat at WIDTH-1.
    applyStimulus(0, 8'h80, 0, firstIdx);
    // Low-first order: 0 then 7.
    applyStimulus(1, 8'b1000_0001, 0, firstIdx);
    applyStimulus(1, 8'b0110_0100, 2, firstIdx);
    // Narrow instance, all ones: 3, 2, 1, 0 with the legacy first answer.
    applyStimulus(2, 8'h0F, 0, firstIdx);
    checkOutput("legacy_first", firstIdx, legacyEncode(4'b1111));
    applyStimulus(2, 8'h00, 1, firstIdx);

    // Reset in the middle of an 8'hFF scan.
    sel = 0;
    @(negedge clk);
    checkOutput("ff_ready", obsReady, 1);
    inVec = 8'hFF; inValid = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("ff_beat0", obsIdx, 7);
    outReady = 1'b1;
    @(negedge clk);
    checkOutput("ff_beat1", obsIdx, 6);
    rst = 1'b1;
    #1;
    checkOutput("midrst_valid", obsValid, 0);
    checkOutput("midrst_busy", obsBusy, 0);
    checkOutput("midrst_idx", obsIdx, 0);
    checkOutput("midrst_last", obsLast, 0);
    checkOutput("midrst_zero", obsZero, 0);
    checkOutput("midrst_ready", obsReady, 0);
    @(negedge clk);
    rst = 1'b0;
    outReady = 1'b0;
    expQ.delete();
    @(negedge clk);
    checkOutput("post_rst_valid", obsValid, 0);
    checkOutput("post_rst_ready", obsReady, 1);
    applyStimulus(0, 8'h08, 0, firstIdx);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/priority_scan_encoder.md
Name: priority_scan_encoder

Overview:
Parametrised, sequential successor to the team's 4-to-2 priority encoder. It accepts an N-bit request vector through a valid/ready handshake and emits the index of every set bit, one index per output beat, in priority order. The output side also uses valid/ready, and the final index is flagged. It sits between request-collection logic, such as interrupt or arbitration vectors, and consumers that service one request at a time.

Parameters:
WIDTH, 8, number of request bits in in_vec (must be 2 or more).
IDXW, $clog2(WIDTH), width of the emitted index.
HIGH_FIRST, 1, scan order: 1 = highest set index first (matches the legacy encoder); 0 = lowest set index first.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_vec is presented.
in_ready  output  1  block can capture a vector.
in_vec  input  WIDTH  request vector.
out_valid  output  1  out_idx/out_last/out_zero are valid.
out_ready  input  1  consumer accepts the current beat.
out_idx  output  IDXW  index of the current highest-priority pending bit.
out_last  output  1  current beat is the final beat for this vector.
out_zero  output  1  captured vector was all-zero.
busy  output  1  a vector is held (state OUT).

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values, all applied immediately on rst:
  - state = IDLE, pending = 0.
  - out_valid = 0, out_idx = 0, out_last = 0, out_zero = 0, busy = 0.
  - in_ready = 0 while rst is high.
- States: IDLE and OUT.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_valid && in_ready at edge N: pending <= in_vec, out_zero <= (in_vec == 0), state <= OUT.
- OUT:
  - in_ready = 0, busy = 1, out_valid = 1 from cycle N+1. Capture-to-first-beat latency is 1 cycle.
  - out_idx is the priority index of pending, selected by HIGH_FIRST.
  - out_last = 1 when pending has exactly one set bit, or when out_zero = 1.
- Beat transfer: a beat completes when out_valid && out_ready.
  - The selected bit is cleared from pending.
  - If out_last was 1, state <= IDLE, and in_ready is 1 on the next cycle.
  - Otherwise the next index is presented on the next cycle.
  - Sustained throughput is one index per clock while out_ready stays high.
- Backpressure: while out_valid = 1 and out_ready = 0, out_idx, out_last and out_zero hold stable. pending is unchanged.
- Zero vector: produces exactly one beat with out_idx = 0, out_zero = 1, out_last = 1. This matches the legacy default of 0.
- Capture rules:
  - No capture is possible in the cycle the last beat completes; the next accept is at the earliest one cycle later.
  - in_vec is ignored whenever in_ready = 0.
- Bit WIDTH-1 set alone gives a single beat with out_idx = WIDTH-1 and out_last = 1. No index wrap-around is possible.
- Reset mid-scan: pending is discarded, outputs return to reset values, and no partial beat is emitted after rst deasserts.
- out_idx and out_last must be derived from registered pending, not from in_vec. The datapath must be pure combinational priority logic with no loops over time.

Test Plan:
1. Reset, then reset released with in_valid = 0: required response is out_valid = 0, busy = 0, out_idx = 0, and in_ready = 1 one cycle after rst deasserts.
2. WIDTH = 8, HIGH_FIRST = 1, out_ready held at 1, in_vec = 8'b1010_0110 accepted at cycle N: required response is out_idx = 7, 5, 2, 1 on cycles N+1 to N+4, out_last = 1 only on the idx-1 beat, and in_ready = 1 at N+5.
3. in_vec = 8'h00: required response is one beat with out_idx = 0, out_zero = 1, out_last = 1, then IDLE.
4. in_vec = 8'b0011_0000 with out_ready held at 0 for 3 cycles after out_valid rises: required response is out_idx held at 5 and out_valid held at 1; after out_ready rises, the beats are 5 then 4 (last).
5. HIGH_FIRST = 0 with in_vec = 8'b1000_0001: required response is out_idx = 0 then 7 (last). With WIDTH = 4, HIGH_FIRST = 1 and in_vec = 4'b1111: required response is 3, 2, 1, 0, and the first beat equals the legacy encoder output.
6. rst asserted during the second beat of 8'hFF: required response is all outputs at reset values immediately. After release, a new vector 8'h08 yields a single beat with out_idx = 3 and out_last = 1.
